// File: rtl/cipher_output_serializer.sv
// Buffers 128-bit ciphertext blocks and emits them as addressed 32-bit words, MSW first.
// Latency: first word valid one cycle after the block write; blocks arriving while full are dropped and flagged.
module cipher_output_serializer #(
    parameter int DEPTH     = 2,
    parameter int ADDR_STEP = 4
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         blk_valid,
    input  logic [127:0] blk_data,
    output logic         blk_ready,
    input  logic         dest_load,
    input  logic [31:0]  dest_base,
    output logic         word_valid,
    output logic [31:0]  word_data,
    output logic [31:0]  word_addr,
    input  logic         word_ready,
    output logic         busy,
    output logic         overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic [127:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [1:0]    word_cnt;
    logic [31:0]   addr_q;
    logic          ovf_q;
    state_t        state;

    logic          full;
    logic          push;
    logic          xfer;
    logic          pop;
    logic          load_ok;
    logic [127:0]  head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full       = (count == CW'(DEPTH));
    assign blk_ready  = !full;
    assign busy       = (count != '0);
    assign push       = blk_valid && !full;
    assign word_valid = (state == SEND);
    assign xfer       = word_valid && word_ready;
    assign pop        = xfer && (word_cnt == 2'd3);
    assign load_ok    = dest_load && !busy;
    assign head       = mem[rd_ptr];
    assign word_addr  = addr_q;
    assign overflow   = ovf_q;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        word_data = '0;
        if (word_valid) begin
            case (word_cnt)
                2'd0:    word_data = head[127:96];
                2'd1:    word_data = head[95:64];
                2'd2:    word_data = head[63:32];
                default: word_data = head[31:0];
            endcase
        end
    end

    // Storage carries no reset: count gates every read, so stale entries are never visible.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= blk_data;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            word_cnt <= '0;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
            state    <= IDLE;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_next;
            if (xfer) begin
                word_cnt <= word_cnt + 2'd1;
            end
            // Load only happens while empty, so it can never race a transfer increment.
            if (load_ok) begin
                addr_q <= dest_base;
            end else if (xfer) begin
                addr_q <= addr_q + 32'(ADDR_STEP);
            end
            if (blk_valid && full) begin
                ovf_q <= 1'b1;
            end else if (load_ok) begin
                ovf_q <= 1'b0;
            end
            state <= (count_next != '0) ? SEND : IDLE;
        end
    end

endmodule

// File: tb/tb_cipher_output_serializer.sv
// Directed bench for cipher_output_serializer: reset, streaming, stall, overflow, wrap, mid-block reset.
module tb_cipher_output_serializer;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_ready;
    logic         dest_load;
    logic [31:0]  dest_base;
    logic         word_valid;
    logic [31:0]  word_data;
    logic [31:0]  word_addr;
    logic         word_ready;
    logic         busy;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] BLK_C = 128'h11111111_22222222_33333333_44444444;

    always #5 HCLK = ~HCLK;

    cipher_output_serializer #(.DEPTH(2), .ADDR_STEP(4)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .blk_ready  (blk_ready),
        .dest_load  (dest_load),
        .dest_base  (dest_base),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_addr  (word_addr),
        .word_ready (word_ready),
        .busy       (busy),
        .overflow   (overflow)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
        return b[127-32*i -: 32];
    endfunction

    task automatic load_base(input logic [31:0] base);
        dest_load = 1'b1;
        dest_base = base;
        tick();
        dest_load = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; blk_valid = 1'b0; blk_data = '0;
        dest_load = 1'b0; dest_base = '0; word_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL rst_vld got %b want 0", word_valid); end
        n_cmp++; if (word_data !== 32'h0) begin n_err++; $display("FAIL rst_data got %h want 0", word_data); end
        n_cmp++; if (word_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", word_addr); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (blk_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", blk_ready); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", overflow); end
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load_base(32'h2000_0000);
        n_cmp++; if (word_addr !== 32'h2000_0000) begin n_err++; $display("FAIL basic_load got %h want 20000000", word_addr); end
        n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL basic_idle got %b want 0", word_valid); end
        word_ready = 1'b1; blk_valid = 1'b1; blk_data = BLK_A;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL basic_vld[%0d] got %b want 1", i, word_valid); end
            n_cmp++; if (word_data !== word_of(BLK_A, i)) begin n_err++; $display("FAIL basic_data[%0d] got %h want %h", i, word_data, word_of(BLK_A, i)); end
            n_cmp++; if (word_addr !== 32'h2000_0000 + 32'(4*i)) begin n_err++; $display("FAIL basic_addr[%0d] got %h want %h", i, word_addr, 32'h2000_0000 + 32'(4*i)); end
            tick();
        end
        n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL basic_end_vld got %b want 0", word_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_end_busy got %b want 0", busy); end
        n_cmp++; if (word_data !== 32'h0) begin n_err++; $display("FAIL basic_end_data got %h want 0", word_data); end
    endtask

    task automatic test_stall();
        load_base(32'h2000_0000);
        word_ready = 1'b1; blk_valid = 1'b1; blk_data = BLK_A;
        tick();
        blk_valid = 1'b0;
        tick();
        word_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (word_data !== 32'h4455_6677) begin n_err++; $display("FAIL stall_data[%0d] got %h want 44556677", k, word_data); end
            n_cmp++; if (word_addr !== 32'h2000_0004) begin n_err++; $display("FAIL stall_addr[%0d] got %h want 20000004", k, word_addr); end
            n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL stall_vld[%0d] got %b want 1", k, word_valid); end
        end
        word_ready = 1'b1;
        tick();
        n_cmp++; if (word_data !== 32'h8899_AABB) begin n_err++; $display("FAIL stall_w2 got %h want 8899aabb", word_data); end
        n_cmp++; if (word_addr !== 32'h2000_0008) begin n_err++; $display("FAIL stall_a2 got %h want 20000008", word_addr); end
        tick(); tick();
        n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL stall_end got %b want 0", word_valid); end
    endtask

    task automatic test_overflow();
        logic [127:0] exp_blk;
        load_base(32'h0000_1000);
        word_ready = 1'b0;
        blk_valid = 1'b1; blk_data = BLK_A;
        tick();
        n_cmp++; if (blk_ready !== 1'b1) begin n_err++; $display("FAIL ovf_rdy1 got %b want 1", blk_ready); end
        blk_data = BLK_B;
        tick();
        n_cmp++; if (blk_ready !== 1'b0) begin n_err++; $display("FAIL ovf_rdy2 got %b want 0", blk_ready); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", overflow); end
        blk_data = BLK_C;
        tick();
        blk_valid = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow); end
        n_cmp++; if (blk_ready !== 1'b0) begin n_err++; $display("FAIL ovf_rdy3 got %b want 0", blk_ready); end
        load_base(32'h0000_5555);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_busy_load got %b want 1", overflow); end
        n_cmp++; if (word_addr !== 32'h0000_1000) begin n_err++; $display("FAIL ovf_busy_addr got %h want 00001000", word_addr); end
        word_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_blk = (i < 4) ? BLK_A : BLK_B;
            n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL ovf_vld[%0d] got %b want 1", i, word_valid); end
            n_cmp++; if (word_data !== word_of(exp_blk, i % 4)) begin n_err++; $display("FAIL ovf_data[%0d] got %h want %h", i, word_data, word_of(exp_blk, i % 4)); end
            n_cmp++; if (word_addr !== 32'h0000_1000 + 32'(4*i)) begin n_err++; $display("FAIL ovf_addr[%0d] got %h want %h", i, word_addr, 32'h0000_1000 + 32'(4*i)); end
            tick();
        end
        n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain got %b want 0", word_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        load_base(32'h0000_0040);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        load_base(32'h0000_8000);
        word_ready = 1'b1; blk_valid = 1'b1; blk_data = BLK_A;
        tick();
        n_cmp++; if (word_data !== 32'h0011_2233) begin n_err++; $display("FAIL b2b_w0 got %h want 00112233", word_data); end
        blk_data = BLK_B;
        tick();
        blk_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL b2b_vld[%0d] got %b want 1", i, word_valid); end
            n_cmp++; if (word_data !== word_of((i < 4) ? BLK_A : BLK_B, i % 4)) begin n_err++; $display("FAIL b2b_data[%0d] got %h", i, word_data); end
            n_cmp++; if (word_addr !== 32'h0000_8000 + 32'(4*i)) begin n_err++; $display("FAIL b2b_addr[%0d] got %h want %h", i, word_addr, 32'h0000_8000 + 32'(4*i)); end
            tick();
        end
        n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b want 0", word_valid); end
    endtask

    task automatic test_push_pop();
        load_base(32'h0000_0100);
        word_ready = 1'b1; blk_valid = 1'b1; blk_data = BLK_A;
        tick();
        blk_valid = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (word_data !== 32'hCCDD_EEFF) begin n_err++; $display("FAIL pp_w3 got %h want ccddeeff", word_data); end
        blk_valid = 1'b1; blk_data = BLK_B;
        tick();
        blk_valid = 1'b0;
        n_cmp++; if (word_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pp_next got %h want deadbeef", word_data); end
        n_cmp++; if (blk_ready !== 1'b1) begin n_err++; $display("FAIL pp_ready got %b want 1", blk_ready); end
        n_cmp++; if (word_addr !== 32'h0000_0110) begin n_err++; $display("FAIL pp_addr got %h want 00000110", word_addr); end
        tick(); tick(); tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL pp_end got %b want 0", busy); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        word_ready = 1'b1;
        dest_load = 1'b1; dest_base = 32'hFFFF_FFF8;
        blk_valid = 1'b1; blk_data = BLK_C;
        tick();
        dest_load = 1'b0; blk_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (word_addr !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr[%0d] got %h want %h", i, word_addr, exp_a[i]); end
            n_cmp++; if (word_data !== word_of(BLK_C, i)) begin n_err++; $display("FAIL wrap_data[%0d] got %h want %h", i, word_data, word_of(BLK_C, i)); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        load_base(32'h0000_3000);
        word_ready = 1'b1; blk_valid = 1'b1; blk_data = BLK_A;
        tick();
        blk_valid = 1'b0;
        tick(); tick();
        HRESETn = 1'b0;
        tick();
        n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL rmid_vld got %b want 0", word_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_cmp++; if (blk_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready got %b want 1", blk_ready); end
        n_cmp++; if (word_addr !== 32'h0) begin n_err++; $display("FAIL rmid_addr got %h want 0", word_addr); end
        n_cmp++; if (word_data !== 32'h0) begin n_err++; $display("FAIL rmid_data got %h want 0", word_data); end
        HRESETn = 1'b1;
        tick(); tick();
        n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL rmid_resume got %b want 0", word_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_push_pop();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cipher_output_serializer.md
CIPHER_OUTPUT_SERIALIZER -- requirements
Module: cipher_output_serializer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clock port HCLK, reset port HRESETn.
REQ-002 Parameter DEPTH SHALL default to 2 and set the number of 128-bit ciphertext blocks buffered.
REQ-003 Parameter ADDR_STEP SHALL default to 4 and set the byte increment of the destination pointer per word.
REQ-004 Port HCLK SHALL be input, 1 bit: rising-edge clock.
REQ-005 Port HRESETn SHALL be input, 1 bit: synchronous active-low reset.
REQ-006 Port blk_valid SHALL be input, 1 bit: one-cycle pulse from the encryption stage marking blk_data valid.
REQ-007 Port blk_data SHALL be input, 128 bits: ciphertext block.
REQ-008 Port blk_ready SHALL be output, 1 bit: high when fewer than DEPTH blocks are buffered.
REQ-009 Port dest_load SHALL be input, 1 bit: load dest_base into the address pointer.
REQ-010 Port dest_base SHALL be input, 32 bits: destination byte address.
REQ-011 Port word_valid SHALL be output, 1 bit: word_data/word_addr valid for the downstream AHB master.
REQ-012 Port word_data SHALL be output, 32 bits: ciphertext word.
REQ-013 Port word_addr SHALL be output, 32 bits: destination byte address of word_data.
REQ-014 Port word_ready SHALL be input, 1 bit: downstream accepts the current word.
REQ-015 Port busy SHALL be output, 1 bit: high when a block is buffered or being sent.
REQ-016 Port overflow SHALL be output, 1 bit: sticky flag, a block arrived while the buffer was full.

Function
REQ-017 The buffer SHALL be a DEPTH-entry circular FIFO of 128-bit blocks with a 0..DEPTH count; blk_ready = (count < DEPTH), combinational from count only.
REQ-018 blk_valid while count < DEPTH SHALL write blk_data at the write pointer and increment count at the next edge.
REQ-019 blk_valid while count == DEPTH SHALL drop the block and set overflow, even if a pop occurs in the same cycle.
REQ-020 FSM states SHALL be IDLE (count==0, word_valid=0) and SEND (head block presented); IDLE->SEND when count becomes nonzero; SEND->IDLE after the 4th word is accepted and count becomes 0.
REQ-021 A block written into an empty buffer at edge N SHALL produce word_valid=1 in the cycle following edge N (one-cycle latency).
REQ-022 Word order SHALL be MSW first: word 0 = [127:96], 1 = [95:64], 2 = [63:32], 3 = [31:0], selected by a 2-bit word counter.
REQ-023 A word transfer SHALL occur on an edge where word_valid && word_ready; on transfer the word counter increments and the address pointer adds ADDR_STEP modulo 2^32.
REQ-024 While word_valid && !word_ready, word_data and word_addr SHALL hold stable.
REQ-025 Transfer of word 3 SHALL pop the head block (count-1, word counter to 0); if count stays nonzero, word_valid SHALL remain high with word 0 of the next block on the next cycle (no bubble).
REQ-026 Simultaneous push and pop with count < DEPTH SHALL leave count unchanged and accept the new block.
REQ-027 dest_load while busy==0 SHALL load the pointer from dest_base and clear overflow; dest_load while busy==1 SHALL be ignored.
REQ-028 dest_load and blk_valid in the same idle cycle SHALL load the pointer first; word 0 of that block uses the new dest_base.
REQ-029 word_data SHALL be 0 whenever word_valid is 0.
REQ-030 busy SHALL equal (count != 0).

Reset
REQ-031 HRESETn low at a rising edge SHALL clear count, both FIFO pointers, the word counter, the address pointer (0), overflow (0), and enter IDLE, giving word_valid=0, word_data=0, word_addr=0, busy=0, blk_ready=1.
REQ-032 Reset asserted mid-block SHALL discard all buffered data; no partial block resumes after reset.

Verification
REQ-033 dest_load with dest_base=0x2000_0000, then blk_valid with blk_data=0x00112233_44556677_8899AABB_CCDDEEFF, word_ready=1 -> words 0x00112233@0x20000000, 0x44556677@0x20000004, 0x8899AABB@0x20000008, 0xCCDDEEFF@0x2000000C on consecutive cycles, starting 1 cycle after the write, then IDLE.
REQ-034 Same block with word_ready low for 3 cycles on word 1 -> word_data=0x44556677, word_addr=0x20000004 held stable for those cycles.
REQ-035 word_ready=0, three blk_valid pulses -> blk_ready=0 after the second, third block dropped, overflow=1; a subsequent idle dest_load clears overflow.
REQ-036 Two back-to-back blocks with word_ready=1 -> 8 consecutive valid words, addresses base..base+0x1C, no gap cycle.
REQ-037 dest_base=0xFFFF_FFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-038 HRESETn low after word 1 of a block -> next cycle word_valid=0, busy=0, blk_ready=1, word_addr=0.
